systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 181 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for a systolic array: buffers one job of input vectors, then
// streams them out with a per-lane diagonal skew and sequences COMPUTE/FLUSH/DONE.

module systolic_feeder_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);
  logic [DEPTH-1:0][W-1:0] r_d;
  logic [DEPTH-1:0]        r_v;

  // Idle slots shift zeros so an invalid lane always reads as 0.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_d <= '0;
      r_v <= '0;
    end else begin
      r_d[0] <= i_vld ? i_data : '0;
      r_v[0] <= i_vld;
      for (int j = 1; j < DEPTH; j++) begin
        r_d[j] <= r_d[j-1];
        r_v[j] <= r_v[j-1];
      end
    end
  end

  assign o_data = r_d[DEPTH-1];
  assign o_vld  = r_v[DEPTH-1];
endmodule

module systolic_feeder #(
  parameter int OPND_BWIDTH  = 8,
  parameter int LANES        = 4,
  parameter int K_MAX        = 16,
  parameter int TAIL         = 4,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic                         IN_LAST,
  input  logic [LANES*OPND_BWIDTH-1:0] IN_DATA,
  output logic [LANES*OPND_BWIDTH-1:0] OPND_out,
  output logic [LANES-1:0]             OPND_is_valid_out,
  output logic                         COMPUTE,
  output logic                         FLUSH,
  output logic                         BUSY,
  output logic                         DONE
);
  localparam int W         = OPND_BWIDTH;
  localparam int IW        = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int CW        = $clog2(K_MAX + 1);
  localparam int DRAIN_LEN = LANES - 1 + TAIL;
  localparam int TMAX      = (DRAIN_LEN > FLUSH_CYCLES) ? DRAIN_LEN : FLUSH_CYCLES;
  localparam int TW        = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_FLUSH, S_FIN
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_idx;
  logic [TW-1:0]           r_tmr;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_compute;
  logic                    r_flush;
  logic                    r_done;
  logic [LANES-1:0][W-1:0] r_buf [K_MAX];

  logic                    w_issue;
  logic                    w_accept;
  logic [LANES-1:0][W-1:0] w_vec;
  logic [LANES-1:0][W-1:0] w_lane_data;

  assign w_issue  = (r_state == S_STREAM);
  assign w_accept = IN_VALID && r_ready;
  assign w_vec    = r_buf[r_idx[IW-1:0]];

  // Control outputs trail the state by one cycle so they line up with the
  // first skew-register stage; IN_READY and BUSY track the state directly.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_tmr     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_compute <= 1'b0;
      r_flush   <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < K_MAX; i++) r_buf[i] <= '0;
    end else begin
      r_compute <= (r_state == S_STREAM) || (r_state == S_DRAIN);
      r_flush   <= (r_state == S_FLUSH);
      r_done    <= (r_state == S_FIN);
      case (r_state)
        S_IDLE, S_LOAD: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_buf[r_cnt[IW-1:0]] <= IN_DATA;
            r_cnt  <= r_cnt + CW'(1);
            r_busy <= 1'b1;
            // A full buffer ends the load phase even without IN_LAST.
            if (IN_LAST || r_cnt == CW'(K_MAX - 1)) begin
              r_state <= S_STREAM;
              r_idx   <= '0;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_STREAM: begin
          if (r_idx == r_cnt - CW'(1)) begin
            r_state <= S_DRAIN;
            r_tmr   <= '0;
          end else begin
            r_idx <= r_idx + CW'(1);
          end
        end
        S_DRAIN: begin
          if (r_tmr == TW'(DRAIN_LEN - 1)) begin
            r_state <= S_FLUSH;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_FLUSH: begin
          if (r_tmr == TW'(FLUSH_CYCLES - 1)) begin
            r_state <= S_FIN;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Lane g sits g extra stages behind lane 0 to form the input wavefront.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    systolic_feeder_lane #(.W(W), .DEPTH(g + 1)) u_lane (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .i_vld  (w_issue),
      .i_data (w_vec[g]),
      .o_vld  (OPND_is_valid_out[g]),
      .o_data (w_lane_data[g])
    );
  end

  assign OPND_out = w_lane_data;
  assign IN_READY = r_ready;
  assign BUSY     = r_busy;
  assign COMPUTE  = r_compute;
  assign FLUSH    = r_flush;
  assign DONE     = r_done;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder against a cycle-indexed reference of
// the skewed operand wavefront and command timeline.

module tb_systolic_feeder;
  localparam int W = 8, L = 4, KM = 8, T = 2, F = 4;

  logic           CLK = 0, RSTn = 1, IN_VALID = 0, IN_LAST = 0;
  logic [L*W-1:0] IN_DATA = '0;
  logic           IN_READY, COMPUTE, FLUSH, BUSY, DONE;
  logic [L*W-1:0] OPND_out;
  logic [L-1:0]   OPND_is_valid_out;

  systolic_feeder #(.OPND_BWIDTH(W), .LANES(L), .K_MAX(KM), .TAIL(T), .FLUSH_CYCLES(F)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_LAST(IN_LAST),
    .IN_DATA(IN_DATA), .OPND_out(OPND_out), .OPND_is_valid_out(OPND_is_valid_out),
    .COMPUTE(COMPUTE), .FLUSH(FLUSH), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0, job = 0;
  logic [L-1:0][W-1:0] vec [KM];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({OPND_out, OPND_is_valid_out, COMPUTE, FLUSH, BUSY, DONE, IN_READY});
  endfunction

  task automatic gen_vec();
    for (int v = 0; v < KM; v++)
      for (int i = 0; i < L; i++) vec[v][i] = W'($urandom);
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    while (IN_READY !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 50) chk("ready_timeout", 64'(IN_READY), 64'(1));
  endtask

  // Hands vectors 0..k-1 to the DUT; returns just after the final accept edge.
  task automatic load_job(input int k, input bit use_last, input bit gaps, output int first_wait);
    int w;
    first_wait = 0;
    for (int v = 0; v < k; v++) begin
      if (gaps && v > 0 && $urandom_range(2) == 0) begin
        IN_VALID = 0;
        @(posedge CLK); #1;
      end
      IN_VALID = 1;
      IN_DATA  = vec[v];
      IN_LAST  = use_last && (v == k - 1);
      wait_ready(w);
      if (v == 0) first_wait = w;
      @(posedge CLK); #1;
      if (v < k - 1) chk($sformatf("j%0d ready_load v%0d", job, v), 64'(IN_READY), 64'(1));
    end
  endtask

  // n = cycles since the final accept edge; C1 is n = 1.
  task automatic check_job(input int k, input bit hold, input int abort_at);
    int nend, dcnt;
    logic [L-1:0][W-1:0] e_d;
    logic [L-1:0]        e_v;
    logic                e_c, e_f, e_dn;
    nend     = k + L + T + F;
    IN_VALID = hold;
    IN_LAST  = hold ? 1'($urandom_range(1)) : 1'b0;
    IN_DATA  = $urandom;
    for (int n = 0; n <= nend; n++) begin
      @(negedge CLK);
      for (int i = 0; i < L; i++) begin
        int t = n - 1 - i;
        e_d[i] = (t >= 0 && t < k) ? vec[t][i] : '0;
        e_v[i] = (t >= 0 && t < k);
      end
      e_c  = (n >= 1) && (n <= k + L - 1 + T);
      e_f  = (n >= k + L + T) && (n <= k + L + T + F - 1);
      e_dn = (n == nend);
      chk($sformatf("j%0d n%0d data", job, n), 64'(OPND_out), 64'(e_d));
      chk($sformatf("j%0d n%0d valid", job, n), 64'(OPND_is_valid_out), 64'(e_v));
      chk($sformatf("j%0d n%0d cmd", job, n), 64'({COMPUTE, FLUSH, DONE}), 64'({e_c, e_f, e_dn}));
      chk($sformatf("j%0d n%0d busy_rdy", job, n), 64'({BUSY, IN_READY}),
          64'({n < nend, n >= nend}));
      if (n == abort_at) begin
        #2 RSTn = 0;
        #1 chk($sformatf("j%0d rst_async", job), all_out(), 64'(0));
        IN_VALID = 0;
        IN_LAST  = 0;
        repeat (2) @(negedge CLK);
        RSTn = 1;
        @(posedge CLK); #1;
        chk($sformatf("j%0d rst_release", job), 64'({BUSY, IN_READY}), 64'(2'b01));
        dcnt = 0;
        repeat (20) begin
          @(negedge CLK);
          if (DONE === 1'b1) dcnt++;
        end
        chk($sformatf("j%0d no_done", job), 64'(dcnt), 64'(0));
        return;
      end
    end
    if (!hold) begin
      IN_VALID = 0;
      IN_LAST  = 0;
    end
  endtask

  task automatic set_k3_pattern();
    gen_vec();
    for (int t = 0; t < 3; t++) begin
      vec[t][0] = W'(t + 1);
      vec[t][3] = W'(-(t + 1));
    end
  endtask

  initial begin
    int fw, k;
    bit last;
    #7 RSTn = 0;
    #1 chk("rst_async", all_out(), 64'(0));
    repeat (2) @(negedge CLK);
    RSTn = 1;
    @(posedge CLK); #1;
    chk("rst_release", 64'({BUSY, IN_READY}), 64'(2'b01));

    job = 1; set_k3_pattern(); load_job(3, 1, 0, fw); check_job(3, 0, -1);
    job = 2; gen_vec(); load_job(1, 1, 0, fw); check_job(1, 0, -1);
    job = 3; gen_vec(); load_job(KM, 0, 1, fw); check_job(KM, 0, -1);

    job = 4; set_k3_pattern(); load_job(3, 1, 0, fw); check_job(3, 1, -1);
    job = 5; gen_vec(); load_job(5, 1, 1, fw);
    chk("b2b_first_wait", 64'(fw), 64'(0));
    check_job(5, 0, -1);

    job = 6; set_k3_pattern(); load_job(3, 1, 0, fw); check_job(3, 0, 2);
    job = 7; gen_vec(); load_job(4, 1, 0, fw); check_job(4, 0, -1);

    for (int r = 0; r < 6; r++) begin
      job  = 8 + r;
      k    = $urandom_range(1, KM);
      last = (k < KM) ? 1'b1 : 1'($urandom_range(1));
      gen_vec();
      load_job(k, last, 1, fw);
      check_job(k, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
